// File: rtl/dense_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dense_layer_sequencer
// Function : Runs one fully-connected layer over 20 lockstep weight banks and a
//            single-port activation RAM; writes saturated Q-format results.
// Revision : 1.0 - initial release
// ============================================================================
module dense_layer_sequencer #(
  parameter int N_IN      = 784,
  parameter int N_OUT     = 20,
  parameter int IN_BASE   = 0,
  parameter int OUT_BASE  = 0,
  parameter int W_BASE    = 0,
  parameter int RD_LAT    = 2,
  parameter int FRAC_BITS = 8,
  parameter int RELU      = 1,
  parameter int ACC_W     = 42
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [19:0][9:0]  w_address,
  input  logic [19:0][15:0] w_q,
  output logic [9:0]        io_address,
  output logic [15:0]       io_d,
  output logic              io_wren,
  input  logic [15:0]       io_q
);

  localparam int         c_banks      = 20;
  localparam logic [9:0] c_in_last    = 10'(N_IN - 1);
  localparam logic [9:0] c_out_last   = 10'(N_OUT - 1);
  localparam logic [9:0] c_drain_last = 10'(RD_LAT - 1);
  localparam logic [9:0] c_in_base    = 10'(IN_BASE);
  localparam logic [9:0] c_out_base   = 10'(OUT_BASE);
  localparam logic [9:0] c_w_base     = 10'(W_BASE);
  localparam logic [9:0] c_bias_addr  = 10'(W_BASE + N_IN);
  localparam logic signed [ACC_W-1:0] c_sat_max = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] c_sat_min = ACC_W'(-32768);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_BIAS  = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_MAC  = 2'd1,
    TAG_BIAS = 2'd2
  } tag_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [9:0]              r_idx;
  logic                    w_idx_clr;
  logic                    w_acc_clr;
  logic [9:0]              w_waddr;
  tag_t                    w_tag_in;
  tag_t                    w_tag_out;
  tag_t                    r_tag [RD_LAT];
  logic signed [ACC_W-1:0] r_acc [c_banks];
  logic signed [ACC_W-1:0] w_sel_acc;
  logic signed [ACC_W-1:0] w_shift;
  logic [15:0]             w_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_clr ? '0 : r_idx + 10'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_clr   = 1'b0;
    w_acc_clr   = 1'b0;
    w_tag_in    = TAG_NONE;
    w_waddr     = '0;
    io_address  = '0;
    io_wren     = 1'b0;
    io_d        = '0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy      = 1'b0;
        w_idx_clr = 1'b1;
        if (start) begin
          w_acc_clr   = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_waddr    = c_w_base + r_idx;
        io_address = c_in_base + r_idx;
        w_tag_in   = TAG_MAC;
        if (r_idx == c_in_last) begin
          w_idx_clr   = 1'b1;
          w_state_nxt = S_BIAS;
        end
      end
      S_BIAS: begin
        w_waddr     = c_bias_addr;
        w_tag_in    = TAG_BIAS;
        w_idx_clr   = 1'b1;
        w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_idx == c_drain_last) begin
          w_idx_clr   = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        io_address = c_out_base + r_idx;
        io_wren    = 1'b1;
        io_d       = w_result;
        if (r_idx == c_out_last) begin
          w_idx_clr   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_idx_clr   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_idx_clr   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  for (genvar k = 0; k < c_banks; k++) begin : g_waddr
    assign w_address[k] = w_waddr;
  end

  // Tags travel alongside the RAM reads so each Q is tagged with what it is.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < RD_LAT; j++) r_tag[j] <= TAG_NONE;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int j = 1; j < RD_LAT; j++) r_tag[j] <= r_tag[j-1];
    end
  end

  assign w_tag_out = r_tag[RD_LAT-1];

  for (genvar k = 0; k < c_banks; k++) begin : g_acc
    logic signed [31:0]      w_prod;
    logic signed [ACC_W-1:0] w_bias;

    assign w_prod = 32'($signed(io_q)) * 32'($signed(w_q[k]));
    assign w_bias = ACC_W'($signed(w_q[k])) <<< FRAC_BITS;

    always_ff @(posedge clk) begin
      if (reset || w_acc_clr) begin
        r_acc[k] <= '0;
      end else if (w_tag_out == TAG_MAC) begin
        r_acc[k] <= r_acc[k] + ACC_W'(w_prod);
      end else if (w_tag_out == TAG_BIAS) begin
        r_acc[k] <= r_acc[k] + w_bias;
      end
    end
  end

  assign w_sel_acc = r_acc[r_idx[4:0]];
  assign w_shift   = w_sel_acc >>> FRAC_BITS;

  always_comb begin
    w_result = w_shift[15:0];
    if ((RELU != 0) && w_shift[ACC_W-1]) begin
      w_result = 16'h0000;
    end else if (w_shift > c_sat_max) begin
      w_result = 16'h7FFF;
    end else if (w_shift < c_sat_min) begin
      w_result = 16'h8000;
    end
  end

endmodule
`default_nettype wire
